// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NRP_MAX   = 4;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Write ports in ascending priority: a higher index wins an address collision.
  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;
  localparam int NWP     = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read ports, ALU/load write ports and the reserve request.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int NRP   = 2
) ();

  logic [NRP*AW-1:0] rd_addr;
  logic [NRP*DW-1:0] rd_data;
  logic [NRP-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ok;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending loads; REGFILE_BYPASS_EN makes lookups return post-edge state.
module regfile_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NRP*AW-1:0] rd_addr_i,
  output logic [NRP-1:0]    rd_busy_o,
  output logic              rsv_ok_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_src;

  // NOTE: combinational blocks use blocking '=' with a default first, so later
  // statements override earlier ones and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    // Set after clear: a new load issued as the old one completes stays busy.
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_src = busy_d;
`else
  assign busy_src = busy_q;
`endif

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NRP; i++) begin
      rd_busy_o[i] = rst_n & busy_src[rd_addr_i[i*AW +: AW]];
    end
  end

  // Register 0 is never busy when ZERO_REG is set, so it always grants.
  assign rsv_ok_o = rst_n & set_en_i & ~busy_q[set_addr_i];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with dual write ports and a busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  typedef logic [DW-1:0] word_t;

  word_t            mem_q [DEPTH];
  word_t            mem_d [DEPTH];
  word_t            mem_src [DEPTH];
  logic [NWP-1:0]   wp_en;
  logic [AW-1:0]    wp_addr [NWP];
  word_t            wp_data [NWP];
  logic [NRP-1:0]   sb_busy;
  logic [NRP*DW-1:0] rd_data;

  assign wp_en[WP_ALU]    = bus.we0;
  assign wp_addr[WP_ALU]  = bus.wa0;
  assign wp_data[WP_ALU]  = bus.wd0;
  assign wp_en[WP_LOAD]   = bus.we1;
  assign wp_addr[WP_LOAD] = bus.wa1;
  assign wp_data[WP_LOAD] = bus.wd1;

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NWP; p++) begin
      if (wp_en[p]) mem_d[wp_addr[p]] = wp_data[p];
    end
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  // NOTE: the storage array is reset on purpose: clearing every register is part
  // of the architectural reset, so this cannot map onto a reset-less RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign mem_src = mem_d;
`else
  assign mem_src = mem_q;
`endif

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRP; i++) begin
      if (i < NRP_MAX && rst_n) rd_data[i*DW +: DW] = mem_src[bus.rd_addr[i*AW +: AW]];
    end
  end

  assign bus.rd_data = rd_data;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NRP      (NRP),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (bus.rsv_en),
    .set_addr_i (bus.rsv_addr),
    .clr_en_i   (bus.we1),
    .clr_addr_i (bus.wa1),
    .rd_addr_i  (bus.rd_addr),
    .rd_busy_o  (sb_busy),
    .rsv_ok_o   (bus.rsv_ok)
  );

  always_comb begin
    bus.rd_busy = '0;
    for (int i = 0; i < NRP; i++) begin
      if (i < NRP_MAX) bus.rd_busy[i] = sb_busy[i];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 16-bit, 8-entry, 4-read-port instance.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DW(32), .DEPTH(32), .NRP(2)) bus ();
  regfile_mp_if #(.DW(16), .DEPTH(8),  .NRP(4)) bus4 ();

  regfile_mp #(.DW(32), .DEPTH(32), .NRP(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_mp #(.DW(16), .DEPTH(8), .NRP(4), .ZERO_REG(1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h required a queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    bus4.we0 = 1'b0; bus4.wa0 = '0; bus4.wd0 = '0;
    bus4.we1 = 1'b0; bus4.wa1 = '0; bus4.wd1 = '0;
    bus4.rsv_en = 1'b0; bus4.rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] pack2(input reg_addr_t a0, input reg_addr_t a1);
    return {a1, a0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    bus.rd_addr  = '0;
    bus4.rd_addr = '0;
    // Reset state, with a reserve request held active.
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd3;
    #2;
    expect_val("reset_rd_data", 64'h0);       check(64'(bus.rd_data));
    expect_val("reset_rd_busy", 64'h0);       check(64'(bus.rd_busy));
    expect_val("reset_rsv_ok", 64'h0);        check(64'(bus.rsv_ok));
    expect_val("reset_p4_rd_data", 64'h0);    check(64'(bus4.rd_data));
    expect_val("reset_p4_rd_busy", 64'h0);    check(64'(bus4.rd_busy));
    idle();
    #10;
    rst_n = 1'b1;

    // Write reg5 and reserve it, then pull reset mid-cycle.
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEAD_BEEF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
    bus.rd_addr = pack2(5'd5, 5'd5);
    expect_val("reg5_written", 64'hDEAD_BEEF);
    expect_val("reg5_busy", 64'h1);
    tick();
    idle();
    check(64'(bus.rd_data[31:0]));
    check(64'(bus.rd_busy[0]));
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_data", 64'h0);    check(64'(bus.rd_data[31:0]));
    expect_val("async_reset_busy", 64'h0);    check(64'(bus.rd_busy));
    #1;
    rst_n = 1'b1;

    // Dual write on one edge.
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h11;
    bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h22;
    bus.rd_addr = pack2(5'd3, 5'd4);
    expect_val("dual_port0_reg3", 64'h11);
    expect_val("dual_port1_reg4", 64'h22);
    tick();
    idle();
    check(64'(bus.rd_data[31:0]));
    check(64'(bus.rd_data[63:32]));

    // Same-address collision: load port wins.
    bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h1;
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h2;
    bus.rd_addr = pack2(5'd7, 5'd3);
    expect_val("collision_reg7", 64'h2);
    expect_val("reg3_kept", 64'h11);
    tick();
    idle();
    check(64'(bus.rd_data[31:0]));
    check(64'(bus.rd_data[63:32]));

    // Zero register ignores writes and reserves.
    bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFF_FFFF;
    bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFF_FFFF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    bus.rd_addr = pack2(5'd0, 5'd0);
    #1;
    expect_val("zero_rsv_ok", 64'h1);         check(64'(bus.rsv_ok));
    expect_val("zero_pre_edge_data", 64'h0);  check(64'(bus.rd_data[31:0]));
    expect_val("zero_data", 64'h0);
    expect_val("zero_busy", 64'h0);
    tick();
    idle();
    check(64'(bus.rd_data[31:0]));
    check(64'(bus.rd_busy[0]));

    // Scoreboard: first reserve of reg9.
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    bus.rd_addr = pack2(5'd9, 5'd0);
    #1;
    expect_val("rsv9_ok", 64'h1);             check(64'(bus.rsv_ok));
`ifdef REGFILE_BYPASS_EN
    expect_val("rsv9_pre_edge_busy", 64'h1);  check(64'(bus.rd_busy[0]));
`else
    expect_val("rsv9_pre_edge_busy", 64'h0);  check(64'(bus.rd_busy[0]));
`endif
    expect_val("rsv9_busy", 64'h1);
    tick();
    idle();
    check(64'(bus.rd_busy[0]));

    // Second reserve of an already-busy register is refused.
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    #1;
    expect_val("rsv9_again_ok", 64'h0);       check(64'(bus.rsv_ok));
    expect_val("rsv9_again_busy", 64'h1);
    tick();
    idle();
    check(64'(bus.rd_busy[0]));

    // Load writeback with a simultaneous reserve: busy stays set.
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h99;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    expect_val("wb_rsv9_busy", 64'h1);
    expect_val("wb_rsv9_data", 64'h99);
    tick();
    idle();
    check(64'(bus.rd_busy[0]));
    check(64'(bus.rd_data[31:0]));

    // Load writeback alone clears busy.
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h77;
    expect_val("wb9_busy_clear", 64'h0);
    expect_val("wb9_data", 64'h77);
    tick();
    idle();
    check(64'(bus.rd_busy[0]));
    check(64'(bus.rd_data[31:0]));

    // ALU write to a register being read in the same cycle.
    bus.we0 = 1'b1; bus.wa0 = 5'd6; bus.wd0 = 32'hA5;
    bus.rd_addr = pack2(5'd6, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("bypass_same_cycle", 64'hA5);  check(64'(bus.rd_data[31:0]));
`else
    expect_val("bypass_same_cycle", 64'h0);   check(64'(bus.rd_data[31:0]));
`endif
    expect_val("reg6_next_cycle", 64'hA5);
    tick();
    idle();
    check(64'(bus.rd_data[31:0]));

    // Narrow, shallow, four-read-port instance.
    bus4.we0 = 1'b1; bus4.wa0 = 3'd1; bus4.wd0 = 16'h1111;
    bus4.we1 = 1'b1; bus4.wa1 = 3'd2; bus4.wd1 = 16'h2222;
    tick();
    bus4.we0 = 1'b1; bus4.wa0 = 3'd5; bus4.wd0 = 16'h5555;
    bus4.we1 = 1'b1; bus4.wa1 = 3'd7; bus4.wd1 = 16'h7777;
    expect_val("p4_port0_reg1", 64'h1111);
    expect_val("p4_port1_reg2", 64'h2222);
    expect_val("p4_port2_reg5", 64'h5555);
    expect_val("p4_port3_reg7", 64'h7777);
    expect_val("p4_busy", 64'h0);
    tick();
    idle();
    bus4.rd_addr = {3'd7, 3'd5, 3'd2, 3'd1};
    #1;
    check(64'(bus4.rd_data[15:0]));
    check(64'(bus4.rd_data[31:16]));
    check(64'(bus4.rd_data[47:32]));
    check(64'(bus4.rd_data[63:48]));
    check(64'(bus4.rd_busy));

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
